scan_loader: RTL and testbench



---
 rtl/scan_loader.sv | 165 ++++++++++++++++
 tb/tb_scan_loader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/scan_loader.sv
// Serial scan-chain host: streams BUFFER_SIZE bytes into one pattern buffer, MSB first.
// Optional SCAN_READBACK_EN captures the displaced old image from sout as a byte stream.
module scan_loader #(
  parameter int unsigned BUFFER_SIZE  = 32,
  parameter int unsigned BUFFER_WIDTH = 8,
  parameter int unsigned NO_BUFS      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(NO_BUFS)-1:0] addr,
  output logic                       busy,
  output logic                       done,
  input  logic [BUFFER_WIDTH-1:0]    wr_data,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  output logic [BUFFER_WIDTH-1:0]    rd_data,
  output logic                       rd_valid,
  output logic                       sclk,
  output logic                       sin,
  output logic                       ssel,
  output logic [$clog2(NO_BUFS)-1:0] saddr,
  input  logic                       sout
);

  localparam int unsigned AddrW = $clog2(NO_BUFS);
  localparam int unsigned CntW  = $clog2(BUFFER_SIZE);
  localparam int unsigned BitW  = $clog2(BUFFER_WIDTH);
  localparam int unsigned Bw    = BUFFER_WIDTH;

  localparam logic [CntW-1:0] LastByte = CntW'(BUFFER_SIZE - 1);
  localparam logic [BitW-1:0] LastBit  = BitW'(BUFFER_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] byte_cnt_q, byte_cnt_d;
  logic [BitW-1:0] bit_cnt_q, bit_cnt_d;
  logic            phase_q, phase_d;
  logic [Bw-1:0]   shreg_q, shreg_d;
  logic            sin_q, sin_d;
  logic            sclk_q, sclk_d;
  logic            ssel_q, ssel_d;
  logic [AddrW-1:0] saddr_q, saddr_d;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    phase_d    = phase_q;
    shreg_d    = shreg_q;
    sin_d      = sin_q;
    saddr_d    = saddr_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StLoad;
          saddr_d    = addr;
          byte_cnt_d = '0;
        end
      end
      StLoad: begin
        if (wr_valid) begin
          state_d   = StShift;
          shreg_d   = wr_data;
          sin_d     = wr_data[Bw-1];
          bit_cnt_d = '0;
          phase_d   = 1'b0;
        end
      end
      StShift: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (bit_cnt_q == LastBit) begin
            if (byte_cnt_q == LastByte) begin
              state_d = StDone;
            end else begin
              byte_cnt_d = byte_cnt_q + CntW'(1);
              state_d    = StLoad;
            end
          end else begin
            // shreg[Bw-1] is the bit on the wire; the next one sits just below it
            bit_cnt_d = bit_cnt_q + BitW'(1);
            sin_d     = shreg_q[Bw-2];
            shreg_d   = {shreg_q[Bw-2:0], 1'b0};
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Scan pins are registered copies of what the next state implies
    sclk_d = (state_d == StShift) && phase_d;
    ssel_d = (state_d == StLoad) || (state_d == StShift);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      byte_cnt_q <= '0;
      bit_cnt_q  <= '0;
      phase_q    <= 1'b0;
      shreg_q    <= '0;
      sin_q      <= 1'b0;
      sclk_q     <= 1'b0;
      ssel_q     <= 1'b0;
      saddr_q    <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      phase_q    <= phase_d;
      shreg_q    <= shreg_d;
      sin_q      <= sin_d;
      sclk_q     <= sclk_d;
      ssel_q     <= ssel_d;
      saddr_q    <= saddr_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign wr_ready = (state_q == StLoad);
  assign sclk     = sclk_q;
  assign sin      = sin_q;
  assign ssel     = ssel_q;
  assign saddr    = saddr_q;

`ifdef SCAN_READBACK_EN
  logic [Bw-1:0] cap_q;
  logic [Bw-1:0] rd_data_q;
  logic          rd_valid_q;

  // sout is taken on the edge that ends phase 0, i.e. as sclk rises
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      if (state_q == StShift && !phase_q) begin
        cap_q <= {cap_q[Bw-2:0], sout};
        if (bit_cnt_q == LastBit) begin
          rd_data_q  <= {cap_q[Bw-2:0], sout};
          rd_valid_q <= 1'b1;
        end
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`else
  logic unused_sout;
  assign unused_sout = sout;
  assign rd_data     = '0;
  assign rd_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_scan_loader.sv
// Randomized self-checking bench for scan_loader with a 256-bit chain model behind sout.
module tb_scan_loader;

  localparam int Size    = 32;
  localparam int DoneCyc = 1 + 17 * Size;

  logic       clk = 1'b0;
  logic       rst, start, wr_valid, sout;
  logic [2:0] addr, saddr;
  logic [7:0] wr_data, rd_data;
  logic       busy, done, wr_ready, rd_valid, sclk, sin, ssel;

  logic [7:0]   tx       [Size];
  logic [7:0]   prev_img [Size];
  logic [255:0] chain;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;
  assign sout = chain[255];

  scan_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .addr     (addr),
    .busy     (busy),
    .done     (done),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .sclk     (sclk),
    .sin      (sin),
    .ssel     (ssel),
    .saddr    (saddr),
    .sout     (sout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({sclk, sin, ssel, saddr, busy, done, wr_ready, rd_valid, rd_data});
  endfunction

  // Runs one frame starting in the current (idle) cycle. Returns in the cycle after DONE,
  // or, when abort_cyc > 0, after rst has been pulsed in that cycle and the aftermath watched.
  task automatic run_frame(input logic [2:0] a, input int stall_len, input int poke_cyc,
                           input int abort_cyc, input bit chk_rd, input string tag);
    int cyc = 0, idx = 0, stall_left = stall_len, done_cyc = -1;
    int ssel_bad = 0, sclk_bad = 0, busy_bad = 0, stall_bad = 0;
    int nbits = 0, bit_bad = 0, nrd = 0, rd_bad = 0, late = 0;
    logic prev_sclk = 1'b0;
    logic exp_bit;
    logic [7:0] cur;
    bit xfer;

    start = 1'b1; addr = a; wr_valid = 1'b1; wr_data = tx[0];
    @(posedge clk); #1;
    cyc = 1; start = 1'b0; addr = ~a;
    while (cyc < 1000) begin
      if (abort_cyc > 0 && cyc == abort_cyc + 1) begin
        check({tag, "_rst_outs"}, all_outs(), 0);
        rst = 1'b0;
        break;
      end
      if (done) begin
        check({tag, "_done_ssel"}, 32'(ssel), 0);
        check({tag, "_done_sclk"}, 32'(sclk), 0);
        done_cyc = cyc;
        break;
      end
      if (!ssel || saddr !== a) ssel_bad++;
      if (!busy) busy_bad++;
      if (sclk) begin
        if (prev_sclk) sclk_bad++;
        if (nbits < 8 * Size) begin
          cur = tx[nbits / 8];
          exp_bit = cur[7 - (nbits % 8)];
          if (sin !== exp_bit) bit_bad++;
        end else begin
          bit_bad++;
        end
        nbits++;
        chain = {chain[254:0], sin};
      end
      prev_sclk = sclk;
      if (rd_valid) begin
        if (chk_rd && (nrd >= Size || rd_data !== prev_img[nrd])) rd_bad++;
        nrd++;
      end
`ifndef SCAN_READBACK_EN
      if (rd_data !== 8'h00) rd_bad++;
`endif
      wr_data = tx[(idx < Size) ? idx : Size - 1];
      if (wr_ready && idx == 3 && stall_left > 0) begin
        wr_valid = 1'b0;
        stall_left--;
        if (sclk || !ssel) stall_bad++;
      end else begin
        wr_valid = (idx < Size);
      end
      xfer = wr_valid && wr_ready;
      if (cyc == poke_cyc) begin
        start = 1'b1; addr = 3'd2;
      end else begin
        start = 1'b0;
      end
      if (cyc == abort_cyc) begin
        check({tag, "_abort_in_phase1"}, 32'(sclk), 1);
        rst = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
      if (xfer) idx++;
    end
    start = 1'b0; wr_valid = 1'b0;

    if (abort_cyc > 0) begin
      check({tag, "_abort_bits"}, 32'(bit_bad), 0);
      repeat (600) begin
        @(posedge clk); #1;
        if (done || busy) late++;
      end
      check({tag, "_no_done_after_rst"}, 32'(late), 0);
      return;
    end

    check({tag, "_done_cycle"}, 32'(done_cyc), 32'(DoneCyc + stall_len));
    check({tag, "_nbits"}, 32'(nbits), 32'(8 * Size));
    check({tag, "_sin_seq"}, 32'(bit_bad), 0);
    check({tag, "_ssel_saddr"}, 32'(ssel_bad), 0);
    check({tag, "_busy"}, 32'(busy_bad), 0);
    check({tag, "_sclk_high_1cyc"}, 32'(sclk_bad), 0);
    check({tag, "_stall"}, 32'(stall_bad + stall_left), 0);
`ifdef SCAN_READBACK_EN
    check({tag, "_rd_count"}, 32'(nrd), 32'(Size));
`else
    check({tag, "_rd_count"}, 32'(nrd), 0);
`endif
    check({tag, "_rd_data"}, 32'(rd_bad), 0);
    @(posedge clk); #1;
    check({tag, "_idle_after"}, 32'({busy, ssel, sclk}), 0);
    for (int i = 0; i < Size; i++) prev_img[i] = tx[i];
  endtask

  initial begin
    int extra;
    rst = 1'b1; start = 1'b0; wr_valid = 1'b0; addr = '0; wr_data = '0;
    chain = {32{8'hA5}};
    for (int i = 0; i < Size; i++) prev_img[i] = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sclk", 32'(sclk), 0);
    check("rst_sin", 32'(sin), 0);
    check("rst_ssel", 32'(ssel), 0);
    check("rst_saddr", 32'(saddr), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_wr_ready", 32'(wr_ready), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < Size; i++) tx[i] = 8'h3C;
    run_frame(3'd5, 0, 0, 0, 1'b1, "readback");

    for (int i = 0; i < Size; i++) tx[i] = 8'(i);
    run_frame(3'd5, 0, 0, 0, 1'b1, "full");

    for (int i = 0; i < Size; i++) tx[i] = 8'($urandom);
    run_frame(3'($urandom_range(0, 7)), 10, 0, 0, 1'b1, "stall");

    for (int i = 0; i < Size; i++) tx[i] = 8'($urandom);
    run_frame(3'd6, 0, 200, 0, 1'b1, "busy_start");
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (busy || ssel) extra++;
    end
    check("no_extra_frame", 32'(extra), 0);

    for (int i = 0; i < Size; i++) tx[i] = 8'($urandom);
    run_frame(3'($urandom_range(0, 7)), 0, 0, 130, 1'b0, "reset_mid");

    for (int i = 0; i < Size; i++) tx[i] = 8'($urandom);
    run_frame(3'($urandom_range(0, 7)), 0, 0, 0, 1'b0, "after_rst");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
